// File: rtl/aes_uart_sequencer_if.sv
// Handshake and operand bundle between the UART byte links, the masked AES core
// and the command sequencer.
interface aes_uart_sequencer_if #(
  parameter int NBYTES = 16
) ();
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic [8*NBYTES-1:0]   aes_key;
  logic [8*NBYTES-1:0]   aes_mask;
  logic [8*NBYTES-1:0]   aes_pt;
  logic                  aes_start;
  logic                  aes_done;
  logic [8*NBYTES-1:0]   aes_ct;
  logic                  io_done;
  logic                  busy;
  logic                  rx_overrun;

  // Sequencer side.
  modport master (
    input  rx_valid, rx_data, tx_ready, aes_done, aes_ct,
    output tx_valid, tx_data, aes_key, aes_mask, aes_pt, aes_start,
           io_done, busy, rx_overrun
  );

  // Environment side: UART links and the AES core.
  modport slave (
    output rx_valid, rx_data, tx_ready, aes_done, aes_ct,
    input  tx_valid, tx_data, aes_key, aes_mask, aes_pt, aes_start,
           io_done, busy, rx_overrun
  );
endinterface

// File: rtl/aes_uart_sequencer.sv
// Command sequencer: loads key/mask/plaintext from UART bytes, runs one masked AES
// encryption, and streams the ciphertext (or a one-byte error code) back out.
module aes_uart_sequencer #(
  parameter int NBYTES  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                 io_clk,
  input  logic                 io_reset,
  aes_uart_sequencer_if.master bus
);
  localparam int BW  = 8 * NBYTES;
  localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [TCW-1:0] LAST_WAIT = TCW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_KEY  = 8'h4B;
  localparam logic [7:0] CMD_MASK = 8'h4D;
  localparam logic [7:0] CMD_ENC  = 8'h45;
  localparam logic [7:0] ERR_CMD  = 8'h3F;
  localparam logic [7:0] ERR_TMO  = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_KEY, S_LOAD_MASK, S_LOAD_PT, S_START, S_WAIT, S_SEND, S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    sh_q, sh_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic             commit_q, commit_d;
  logic [TCW-1:0]   tmo_q, tmo_d;
  logic [BW-1:0]    key_q, key_d;
  logic [BW-1:0]    mask_q, mask_d;
  logic [BW-1:0]    pt_q, pt_d;
  logic [7:0]       err_q, err_d;
  logic             io_done_q, io_done_d;
  logic             overrun_q, overrun_d;

  logic             tx_valid_c;
  logic [7:0]       tx_data_c;
  logic             aes_start_c;

  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every target a
    // default first, so no path can leave a value unassigned and infer a latch.
    state_d     = state_q;
    sh_d        = sh_q;
    byte_cnt_d  = byte_cnt_q;
    commit_d    = 1'b0;
    tmo_d       = tmo_q;
    key_d       = key_q;
    mask_d      = mask_q;
    pt_d        = pt_q;
    err_d       = err_q;
    io_done_d   = io_done_q;
    overrun_d   = overrun_q;
    tx_valid_c  = 1'b0;
    tx_data_c   = 8'h00;
    aes_start_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          io_done_d  = 1'b0;
          byte_cnt_d = '0;
          case (bus.rx_data)
            CMD_KEY:  state_d = S_LOAD_KEY;
            CMD_MASK: state_d = S_LOAD_MASK;
            CMD_ENC:  state_d = S_LOAD_PT;
            default: begin
              err_d   = ERR_CMD;
              state_d = S_ERR;
            end
          endcase
        end
      end

      S_LOAD_KEY, S_LOAD_MASK, S_LOAD_PT: begin
        // The commit cycle follows the final byte; operands only ever change here.
        if (commit_q) begin
          if (state_q == S_LOAD_KEY)       key_d  = sh_q;
          else if (state_q == S_LOAD_MASK) mask_d = sh_q;
          else                             pt_d   = sh_q;
          state_d = (state_q == S_LOAD_PT) ? S_START : S_IDLE;
        end else if (bus.rx_valid) begin
          sh_d = {sh_q[BW-9:0], bus.rx_data};
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            commit_d   = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_START: begin
        aes_start_c = 1'b1;
        tmo_d       = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A completion landing on the final wait cycle still wins over the timeout.
        if (bus.aes_done) begin
          sh_d       = bus.aes_ct;
          byte_cnt_d = '0;
          state_d    = S_SEND;
        end else if (tmo_q == LAST_WAIT) begin
          err_d   = ERR_TMO;
          state_d = S_ERR;
        end
      end

      S_SEND: begin
        tx_valid_c = 1'b1;
        tx_data_c  = sh_q[BW-1 -: 8];
        if (bus.tx_ready) begin
          sh_d = {sh_q[BW-9:0], 8'h00};
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            io_done_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_ERR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = err_q;
        if (bus.tx_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (bus.rx_valid && (state_q inside {S_START, S_WAIT, S_SEND, S_ERR}))
      overrun_d = 1'b1;
  end

  always_ff @(posedge io_clk or negedge io_reset) begin
    // NOTE: the committed operand registers are reset as well, so an aborted run
    // never leaves key material visible to the core.
    if (!io_reset) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      byte_cnt_q <= '0;
      commit_q   <= 1'b0;
      tmo_q      <= '0;
      key_q      <= '0;
      mask_q     <= '0;
      pt_q       <= '0;
      err_q      <= 8'h00;
      io_done_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      byte_cnt_q <= byte_cnt_d;
      commit_q   <= commit_d;
      tmo_q      <= tmo_d;
      key_q      <= key_d;
      mask_q     <= mask_d;
      pt_q       <= pt_d;
      err_q      <= err_d;
      io_done_q  <= io_done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.tx_valid   = tx_valid_c;
  assign bus.tx_data    = tx_data_c;
  assign bus.aes_start  = aes_start_c;
  assign bus.aes_key    = key_q;
  assign bus.aes_mask   = mask_q;
  assign bus.aes_pt     = pt_q;
  assign bus.io_done    = io_done_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.rx_overrun = overrun_q;
endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Scoreboard bench for aes_uart_sequencer: stimulus pushes expected tx bytes, a
// negedge monitor pops and compares them on every tx handshake.
module tb_aes_uart_sequencer;
  localparam int NB  = 16;
  localparam int TMO = 20;
  localparam int BW  = 8 * NB;

  typedef logic [7:0] blk_t [NB];
  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         done_exp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_uart_sequencer_if #(.NBYTES(NB)) bus ();

  aes_uart_sequencer #(.NBYTES(NB), .TIMEOUT(TMO)) dut (
    .io_clk   (clk),
    .io_reset (rst_n),
    .bus      (bus.master)
  );

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            hs_count = 0;
  int            n_starts = 0;
  int            start_cyc = 0;
  int            last_byte_cyc = 0;
  int            core_delay = 10;
  logic [BW-1:0] core_ct = '0;
  int            ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int            stall_at = -1;
  int            stall_left = 0;

  // Reference state, derived from the command protocol alone.
  logic [BW-1:0] m_key = '0, m_mask = '0, m_pt = '0;
  bit            m_done = 1'b0, m_overrun = 1'b0;

  bit            chk_done_pending = 1'b0;
  bit            chk_done_val = 1'b0;
  bit            prev_stall = 1'b0;
  logic [7:0]    prev_data = 8'h00;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack(input blk_t b);
    logic [BW-1:0] v;
    for (int i = 0; i < NB; i++) v[BW-1-8*i -: 8] = b[i];
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (chk_done_pending) begin
      check("io_done after block", BW'(bus.io_done), BW'(chk_done_val));
      chk_done_pending = 1'b0;
    end
    if (rst_n && bus.tx_valid && prev_stall)
      check("tx_data stable while stalled", BW'(bus.tx_data), BW'(prev_data));
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected tx: got %h expected no transfer", bus.tx_data);
      end else begin
        e = sb.pop_front();
        check("tx byte", BW'(bus.tx_data), BW'(e.data));
        if (e.last) begin
          chk_done_pending = 1'b1;
          chk_done_val     = e.done_exp;
        end
      end
    end
    prev_stall = rst_n && bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
  end

  // AES core model: fixed-latency completion returning a bench-chosen ciphertext.
  initial begin
    bus.aes_done = 1'b0;
    bus.aes_ct   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.aes_start) begin
        n_starts++;
        start_cyc = cyc;
        check("start latency", BW'(cyc - last_byte_cyc), BW'(2));
        check("key at start", bus.aes_key, m_key);
        check("mask at start", bus.aes_mask, m_mask);
        check("pt at start", bus.aes_pt, m_pt);
        if (core_delay > 0) begin
          repeat (core_delay) @(posedge clk);
          #1;
          bus.aes_done = 1'b1;
          bus.aes_ct   = core_ct;
          @(posedge clk);
          #1;
          bus.aes_done = 1'b0;
          bus.aes_ct   = '0;
        end
      end
    end
  end

  // Transmitter ready driver.
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_at >= 0 && hs_count == stall_at) begin
        stall_at   = -1;
        stall_left = 7;
      end
      if (stall_left > 0) begin
        bus.tx_ready = 1'b0;
        stall_left--;
      end else begin
        case (ready_mode)
          0:       bus.tx_ready = 1'b1;
          1:       bus.tx_ready = 1'($urandom_range(0, 1));
          default: bus.tx_ready = 1'b0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid  = 1'b1;
    bus.rx_data   = b;
    last_byte_cyc = cyc;
    tick();
    bus.rx_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((bus.busy || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
      sb.delete();
    end
    tick();
  endtask

  task automatic check_regs(input string tag);
    check({tag, " aes_key"}, bus.aes_key, m_key);
    check({tag, " aes_mask"}, bus.aes_mask, m_mask);
    check({tag, " aes_pt"}, bus.aes_pt, m_pt);
    check({tag, " io_done"}, BW'(bus.io_done), BW'(m_done));
    check({tag, " rx_overrun"}, BW'(bus.rx_overrun), BW'(m_overrun));
    check({tag, " busy"}, BW'(bus.busy), '0);
  endtask

  task automatic load(input logic [7:0] cmd, input blk_t b);
    m_done = 1'b0;
    send_byte(cmd);
    foreach (b[i]) send_byte(b[i]);
    if (cmd == 8'h4B) m_key = pack(b);
    else              m_mask = pack(b);
    wait_idle("load", 50);
    check_regs("load");
  endtask

  task automatic bad_cmd(input logic [7:0] b);
    exp_t e;
    e.data = 8'h3F; e.last = 1'b1; e.done_exp = 1'b0;
    sb.push_back(e);
    m_done = 1'b0;
    send_byte(b);
    wait_idle("bad command", 200);
    check_regs("bad command");
  endtask

  // delay: core response latency after aes_start (<=0: never). inject: cycles after
  // aes_start at which a stray byte is sent (<=0: none).
  task automatic encrypt(input blk_t b, input logic [BW-1:0] ct, input int delay, input int inject);
    exp_t e;
    int   n0 = n_starts;
    int   n = 0;
    bit   seen = 1'b0;
    bit   resp = (delay >= 1 && delay <= TMO);
    core_ct    = ct;
    core_delay = delay;
    if (resp) begin
      for (int i = 0; i < NB; i++) begin
        e.data = ct[BW-1-8*i -: 8]; e.last = (i == NB-1); e.done_exp = 1'b1;
        sb.push_back(e);
      end
    end else begin
      e.data = 8'h54; e.last = 1'b1; e.done_exp = 1'b0;
      sb.push_back(e);
    end
    m_pt   = pack(b);
    m_done = 1'b0;
    send_byte(8'h45);
    foreach (b[i]) send_byte(b[i]);
    while (!seen && n < 300) begin
      if (bus.tx_valid) begin
        seen = 1'b1;
      end else begin
        if (inject > 0 && n_starts > n0 && cyc - start_cyc == inject) begin
          send_byte(8'h4B);
          m_overrun = 1'b1;
          check("rx_overrun after stray byte", BW'(bus.rx_overrun), BW'(1));
        end else begin
          tick();
        end
        n++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL tx_valid wait: no output after 300 cycles, expected a response");
    end else begin
      check("first tx latency", BW'(cyc - start_cyc), BW'((resp ? delay : TMO) + 1));
    end
    wait_idle("encrypt", 400);
    check("start pulses", BW'(n_starts - n0), BW'(1));
    m_done = resp;
    check_regs("encrypt");
  endtask

  initial begin
    blk_t          kb, mb, pb, rb;
    logic [BW-1:0] ct_vec = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [7:0]    x;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    for (int i = 0; i < NB; i++) begin
      kb[i] = 8'(i);
      mb[i] = 8'hA5;
      pb[i] = 8'(i * 17);
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_valid", BW'(bus.tx_valid), '0);
    check("reset tx_data", BW'(bus.tx_data), '0);
    check("reset aes_start", BW'(bus.aes_start), '0);
    check_regs("reset");
    rst_n = 1'b1;
    tick();

    // Known-answer vector.
    load(8'h4B, kb);
    check("key vector", bus.aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    load(8'h4D, mb);
    encrypt(pb, ct_vec, 10, 0);
    check("pt vector", bus.aes_pt, 128'h00112233445566778899aabbccddeeff);

    // Backpressure: random ready plus a 7-cycle stall mid-block.
    ready_mode = 1;
    stall_at   = hs_count + 8;
    encrypt(pb, ct_vec, 10, 0);

    // Bad command, then a normal encryption.
    bad_cmd(8'h00);
    encrypt(pb, {$urandom, $urandom, $urandom, $urandom}, 7, 0);

    // Timeout, and completion on the timeout cycle.
    ready_mode = 0;
    encrypt(pb, ct_vec, -1, 0);
    encrypt(pb, ct_vec, TMO, 0);

    // Stray byte during WAIT.
    encrypt(pb, {$urandom, $urandom, $urandom, $urandom}, 10, 3);

    // Randomized command mix.
    for (int r = 0; r < 10; r++) begin
      foreach (rb[i]) rb[i] = 8'($urandom);
      ready_mode = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: load(8'h4B, rb);
        1: load(8'h4D, rb);
        2: encrypt(rb, {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(1, 24)), 0);
        default: begin
          x = 8'($urandom);
          while (x == 8'h4B || x == 8'h4D || x == 8'h45) x = 8'($urandom);
          bad_cmd(x);
        end
      endcase
    end

    // Reset in the middle of SEND.
    ready_mode = 2;
    core_ct    = ct_vec;
    core_delay = 5;
    m_pt       = pack(pb);
    send_byte(8'h45);
    foreach (pb[i]) send_byte(pb[i]);
    begin
      int n = 0;
      while (!bus.tx_valid && n < 100) begin
        tick();
        n++;
      end
      check("reached SEND before reset", BW'(bus.tx_valid), BW'(1));
    end
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_key = '0; m_mask = '0; m_pt = '0; m_done = 1'b0; m_overrun = 1'b0;
    check("reset mid-send tx_valid", BW'(bus.tx_valid), '0);
    check_regs("reset mid-send");
    tick();
    rst_n      = 1'b1;
    ready_mode = 0;
    repeat (20) tick();
    check("no tx after reset", BW'(bus.tx_valid), '0);
    check_regs("after reset");

    // Normal operation resumes.
    load(8'h4B, kb);
    encrypt(pb, ct_vec, 10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
